// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder_arbiter block.
package adder_arbiter_pkg;

    // Width of each per-requester grant counter (stats build only).
    localparam int STAT_W = 16;

    // Response register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Sign-extends the low 'width' bits of value to 33 bits.
    // The caller truncates the result to the width it needs.
    function automatic logic [32:0] sign_extend(input logic [31:0] value, input int width);
        logic [32:0] r;
        r = '0;
        for (int i = 0; i < 33; i++) begin
            r[i] = (i < width) ? value[i] : value[width-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared parameterised two-operand adder. Operands arrive already
// extended by one bit, so the WIDTH-bit result cannot overflow.
module adder #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches req starting at the pointer, wrapping,
// and moves the pointer just past the winner when advance is strobed.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] ptr_q;

    // First requester at or after ptr_q (modulo N) wins.
    always_comb begin
        int   j;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                winner   = IW'(j);
            end
        end
    end

    // Pointer only moves on an accepted grant; idle and stalled cycles keep it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (winner == IW'(N-1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared signed adder with a single registered response slot.
// Optional per-requester grant counters are built when the macro
// ADDER_ARBITER_STATS_EN is defined (adds port grant_count).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int IN_WIDTH = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
`ifdef ADDER_ARBITER_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]    grant_count,
`endif
    output logic [IN_WIDTH:0]            resp_sum
);

    out_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       win_idx;
    logic                  can_accept;
    logic                  accept;
    logic [IN_WIDTH-1:0]   a_sel, b_sel;
    logic [IN_WIDTH:0]     a_ext, b_ext;
    logic [IN_WIDTH:0]     add_sum;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .winner  (win_idx)
    );

    // The slot can take a new result when empty or when it drains this cycle.
    assign can_accept = (state_q == EMPTY) || resp_ready;
    assign req_ready  = grant & {NUM_REQ{can_accept}};
    assign accept     = can_accept && (|grant);
    assign resp_valid = (state_q == FULL);

    assign a_sel = req_a[int'(win_idx)*IN_WIDTH +: IN_WIDTH];
    assign b_sel = req_b[int'(win_idx)*IN_WIDTH +: IN_WIDTH];
    assign a_ext = (IN_WIDTH+1)'(sign_extend(32'(a_sel), IN_WIDTH));
    assign b_ext = (IN_WIDTH+1)'(sign_extend(32'(b_sel), IN_WIDTH));

    adder #(.WIDTH(IN_WIDTH+1)) u_add (
        .a   (a_ext),
        .b   (b_ext),
        .sum (add_sum)
    );

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill on accept; drain to EMPTY only when the consumer takes it and nothing refills.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (accept) state_d = FULL;
                     else if (resp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Response payload; held whenever nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sum <= '0;
            resp_id  <= '0;
        end else if (accept) begin
            resp_sum <= add_sum;
            resp_id  <= win_idx;
        end
    end

`ifdef ADDER_ARBITER_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];

    // Per-requester accepted-grant counters, wrapping at 2^STAT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (accept) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_count[g*STAT_W +: STAT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a reference arbitration model
// and a scoreboard of expected responses.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic [1:0]        id;
        logic signed [W:0] sum;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a = '0;
    logic [N*W-1:0]     req_b = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [1:0]         resp_id;
    logic signed [W:0]  resp_sum;
`ifdef ADDER_ARBITER_STATS_EN
    logic [N*STAT_W-1:0] grant_count;
`endif

    int   nvec = 0;
    int   nerr = 0;
    exp_t sbq[$];

    // reference model state, owned by the monitor
    logic        m_full = 1'b0;
    int          m_ptr  = 0;
    logic [15:0] m_cnt [N];

    adder_arbiter #(.NUM_REQ(N), .IN_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
`ifdef ADDER_ARBITER_STATS_EN
        .grant_count(grant_count),
`endif
        .resp_sum   (resp_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_valid[i]    = 1'b1;
    endtask

    function automatic logic signed [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] ea, eb;
        ea = $signed({a[W-1], a});
        eb = $signed({b[W-1], b});
        return ea + eb;
    endfunction

    // Reference model: expected grant, response occupancy and scoreboard.
    always @(negedge clk) begin
        logic [N-1:0] exp_grant;
        logic         found;
        logic         can;
        int           win;
        int           j;
        exp_t         e;
        if (rst) begin
            sbq.delete();
            m_full = 1'b0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else begin
            exp_grant = '0;
            found     = 1'b0;
            win       = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && req_valid[j]) begin
                    found        = 1'b1;
                    exp_grant[j] = 1'b1;
                    win          = j;
                end
            end
            can = !m_full || resp_ready;
            chk("mon_req_ready", req_ready, can ? exp_grant : '0);
            chk("mon_resp_valid", resp_valid, m_full);
            if (m_full && resp_ready) begin
                chk("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("sb_id", resp_id, e.id);
                    chk("sb_sum", resp_sum, e.sum);
                end
            end
            if (can && found) begin
                e.id  = 2'(win);
                e.sum = model_sum(req_a[win*W +: W], req_b[win*W +: W]);
                sbq.push_back(e);
                m_ptr      = (win + 1) % N;
                m_full     = 1'b1;
                m_cnt[win] = m_cnt[win] + 1'b1;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [W:0] held;

        resp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        mid();
        chk("rst_valid", resp_valid, 0);
        chk("rst_sum", resp_sum, 0);
        chk("rst_id", resp_id, 0);
`ifdef ADDER_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) chk("rst_count", grant_count[i*STAT_W +: STAT_W], 0);
`endif

        // single request, requester 0
        tick();
        drive(0, 7641, 4611);
        mid();
        chk("t1_ready", req_ready, 1);
        tick();
        req_valid = '0;
        mid();
        chk("t1_valid", resp_valid, 1);
        chk("t1_id", resp_id, 0);
        chk("t1_sum", resp_sum, 12252);
        chk("t1_ready_drop", req_ready, 0);
        tick();
        mid();
        chk("t1_drain", resp_valid, 0);

        // negative and mixed operands
        tick();
        drive(2, -20785, -6903);
        mid();
        tick();
        req_valid = '0;
        drive(3, -30974, 26651);
        mid();
        chk("neg_id", resp_id, 2);
        chk("neg_sum", resp_sum, -27688);
        tick();
        req_valid = '0;
        mid();
        chk("mix_id", resp_id, 3);
        chk("mix_sum", resp_sum, -4323);

        // extremes, no wrap
        tick();
        drive(2, -32768, -32768);
        mid();
        tick();
        req_valid = '0;
        drive(3, 32767, 32767);
        mid();
        chk("min_sum", resp_sum, -65536);
        tick();
        req_valid = '0;
        mid();
        chk("max_sum", resp_sum, 65534);

        // fairness: all requesters valid, pointer starts at 0
        tick();
        for (int i = 0; i < N; i++)
            drive(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("fair_ready", req_ready, 1 << (k % N));
            if (k > 0) chk("fair_id", resp_id, (k - 1) % N);
            tick();
        end

        // single continuously valid requester
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("solo_ready", req_ready, 2);
            chk("solo_id", resp_id, (k == 0) ? 3 : 1);
            tick();
        end

        // backpressure: slot full with requester 1's result, ptr at 2
        held = model_sum(req_a[1*W +: W], req_b[1*W +: W]);
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", resp_valid, 1);
            chk("bp_id", resp_id, 1);
            chk("bp_sum", resp_sum, held);
            tick();
        end
        resp_ready = 1'b1;
        mid();
        chk("bp_resume_ready", req_ready, 8);
        tick();
        req_valid[3] = 1'b0;
        mid();
        chk("bp_refill_valid", resp_valid, 1);
        chk("bp_refill_id", resp_id, 3);
        chk("bp_next_ready", req_ready, 2);
        tick();
        req_valid = '0;
        mid();
        chk("bp_next_id", resp_id, 1);

        // reset while full with requesters 1 and 3 pending, ptr at 1
        tick();
        drive(0, 100, -50);
        mid();
        tick();
        req_valid  = 4'b1010;
        resp_ready = 1'b0;
        rst        = 1'b1;
        mid();
        tick();
        rst        = 1'b0;
        resp_ready = 1'b1;
        mid();
        chk("rst2_valid", resp_valid, 0);
        chk("rst2_ready", req_ready, 2);
`ifdef ADDER_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) chk("rst2_count", grant_count[i*STAT_W +: STAT_W], 0);
`endif
        tick();
        req_valid[1] = 1'b0;
        mid();
        chk("rst2_id", resp_id, 1);
        chk("rst2_next_ready", req_ready, 8);
        tick();
        req_valid = '0;
        mid();
        chk("rst2_next_id", resp_id, 3);

        // drain and final bookkeeping
        repeat (3) tick();
        mid();
        chk("sb_empty", sbq.size(), 0);
`ifdef ADDER_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) chk("final_count", grant_count[i*STAT_W +: STAT_W], m_cnt[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
